traffic_light_ctrl: RTL
=======================

// Module: traffic_light_ctrl
// PURPOSE
//  Parametrised single-approach traffic light sequencer: LEFT+RED -> GREEN -> YELLOW -> RED, with per-phase durations.
//  Emergency preemption forces all-stop and resumes the interrupted cycle afterwards.
//  Optional safe clearance phase inserts yellow before all-stop when preempted out of LEFT/GREEN.
//  One instance drives each approach; the intersection top ties instances to a common emergency input.
// PARAMETERS
//  LEFT_CYC    5   cycles in LEFT+RED phase (>=1)
//  GREEN_CYC   10  cycles in GREEN phase (>=1)
//  YELLOW_CYC  3   cycles in YELLOW phase, also CLEAR phase length (>=1)
//  RED_CYC     18  cycles in RED phase (>=1)
//  CNT_W       5   phase counter width; every *_CYC-1 must fit (elaboration-time check)
//  EMERG_MIN   2   minimum cycles spent in ALLSTOP (>=1)
//  SAFE_CLEAR  1   1: preemption from LEFT/GREEN passes through CLEAR; 0: immediate ALLSTOP
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  emergency   in   1      emergency vehicle present, sampled on rising clk
//  out         out  4      [3]=left, [2]=green, [1]=yellow, [0]=red
//  phase       out  3      current state encoding (see package)
//  cnt_remain  out  CNT_W  cycles remaining in current phase after this one; 0 in ALLSTOP
//  preempted   out  1      high in CLEAR and ALLSTOP
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LEFT, cnt=0, saved_state=LEFT, saved_cnt=0, stop_cnt=0;
//   out=4'b1001, phase=LEFT, cnt_remain=LEFT_CYC-1, preempted=0. Takes effect immediately, any state.
//  Outputs are a pure decode of registered state/cnt; no combinational path from emergency.
//  Encodings out: LEFT 1001, GREEN 0100, YELLOW 0010, RED 0001, CLEAR 0010, ALLSTOP 0001.
//  Normal: phase P holds for P_CYC cycles, cnt 0..P_CYC-1; at cnt=P_CYC-1 next edge loads next phase, cnt=0.
//   RED wraps to LEFT; full period = LEFT_CYC+GREEN_CYC+YELLOW_CYC+RED_CYC (36 at defaults).
//  Define (nxt_state,nxt_cnt) = value normal sequencing would load at this edge.
//  Emergency=1 at an edge while in YELLOW or RED (or any normal phase if SAFE_CLEAR=0):
//   state<=ALLSTOP, stop_cnt<=0, saved_state<=nxt_state, saved_cnt<=nxt_cnt.
//  Emergency=1 while in LEFT/GREEN and SAFE_CLEAR=1:
//   state<=CLEAR, cnt<=0, saved_state<=RED, saved_cnt<=0 (interrupted green never resumes).
//  CLEAR: YELLOW_CYC cycles, emergency ignored; then ALLSTOP, stop_cnt=0.
//  ALLSTOP: stop_cnt saturates at EMERG_MIN-1; exit at edge where emergency=0 AND stop_cnt==EMERG_MIN-1;
//   exit loads state<=saved_state, cnt<=saved_cnt. Emergency=1 on would-be exit edge keeps ALLSTOP.
//  Emergency on last cycle of a phase: saved = following phase, cnt 0.
//  Phase held in the cycle emergency is first high; preemption visible from next cycle.
//  Illegal state encodings recover to LEFT, cnt=0 on next edge.
// STRUCTURE
//  Package traffic_light_pkg: phase_e enum (LEFT=0,GREEN=1,YELLOW=2,RED=3,ALLSTOP=4,CLEAR=5),
//   light constants LIGHT_LEFT/GREEN/YELLOW/RED, phase_len() function mapping phase to *_CYC.
//  Sub-module tl_phase_timer: CNT_W up-counter with load, terminal flag (cnt==len-1), remain output.
//  Top: state register, saved_state/saved_cnt, stop_cnt, output decode.
// TESTING (defaults unless stated)
//  1 Release reset, emergency=0 -> 1001 x5, 0100 x10, 0010 x3, 0001 x18, repeat; period 36 across 3 periods.
//  2 1-cycle emergency in RED cnt=7 -> ALLSTOP x2 (preempted=1), RED resumes cnt=8, 10 more RED, total RED 20.
//  3 Emergency in GREEN cnt=3 -> CLEAR 0010 x3, ALLSTOP x2, RED cnt=0 x18, then LEFT.
//  4 Emergency held 10 cycles starting YELLOW cnt=0 -> ALLSTOP until emergency low, YELLOW resumes cnt=1, 2 more cycles.
//  5 Emergency in RED cnt=17 -> after ALLSTOP resumes LEFT cnt=0; SAFE_CLEAR=0, GREEN cnt=3 -> ALLSTOP, resume GREEN cnt=4.
//  6 rst_n low mid-ALLSTOP, asynchronous to clk -> out=1001, phase=LEFT, preempted=0 immediately; normal cycle after release.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase encodings, light patterns and phase length/sequence helpers
package traffic_light_pkg;
  typedef enum logic [2:0] {
    LEFT    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    RED     = 3'd3,
    ALLSTOP = 3'd4,
    CLEAR   = 3'd5
  } phase_e;
  localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0001;
  // CLEAR reuses the yellow duration; untimed states report a length of 1
  function automatic int phase_len(phase_e p, int left_cyc, int green_cyc, int yellow_cyc, int red_cyc);
    return p == LEFT ? left_cyc : p == GREEN ? green_cyc : p == RED ? red_cyc :
           (p == YELLOW || p == CLEAR) ? yellow_cyc : 1;
  endfunction
  function automatic phase_e next_phase(phase_e p);
    return p == LEFT ? GREEN : p == GREEN ? YELLOW : p == YELLOW ? RED : LEFT;
  endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: phase cycle counter with load, terminal flag and remaining-cycles output
module tl_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [CNT_W:0]   len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o,
  output logic [CNT_W-1:0] remain_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   last;
  always_comb cnt_d = load_i ? load_val_i : inc_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign last     = len_i - 1'b1;
  assign cnt_o    = cnt_q;
  assign term_o   = {1'b0, cnt_q} == last;
  assign remain_o = CNT_W'(last - {1'b0, cnt_q});
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: single-approach light sequencer with emergency preemption and resume
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int RED_CYC    = 18,
  parameter int CNT_W      = 5,
  parameter int EMERG_MIN  = 2,
  parameter int SAFE_CLEAR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             emergency,
  output logic [3:0]       out,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cnt_remain,
  output logic             preempted
);
  localparam int LW = CNT_W + 1;
  localparam int SW = EMERG_MIN > 1 ? $clog2(EMERG_MIN) : 1;
  localparam logic [SW-1:0] STOP_LAST = SW'(EMERG_MIN - 1);
  if (LEFT_CYC < 1 || GREEN_CYC < 1 || YELLOW_CYC < 1 || RED_CYC < 1 || EMERG_MIN < 1 ||
      LEFT_CYC > 2**CNT_W || GREEN_CYC > 2**CNT_W || YELLOW_CYC > 2**CNT_W || RED_CYC > 2**CNT_W)
  begin : g_bad_params
    $error("traffic_light_ctrl: phase lengths must be >=1 and each length-1 must fit in CNT_W bits");
  end
  phase_e           state_q, state_d, saved_state_q, saved_state_d, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt, saved_cnt_q, saved_cnt_d, load_val, remain;
  logic [SW-1:0]    stop_q, stop_d;
  logic [LW-1:0]    len;
  logic             load, inc, term;
  assign len = LW'(phase_len(state_q, LEFT_CYC, GREEN_CYC, YELLOW_CYC, RED_CYC));
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .inc_i      (inc),
    .len_i      (len),
    .cnt_o      (cnt),
    .term_o     (term),
    .remain_o   (remain)
  );
  // what plain sequencing would load at this edge; preemption saves it for the resume
  assign nxt_state = term ? next_phase(state_q) : state_q;
  assign nxt_cnt   = term ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= LEFT;
      saved_state_q <= LEFT;
      saved_cnt_q   <= '0;
      stop_q        <= '0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
      stop_q        <= stop_d;
    end
  always_comb begin
    state_d       = state_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    stop_d        = stop_q;
    load          = 1'b0;
    load_val      = '0;
    inc           = 1'b0;
    case (state_q)
      LEFT, GREEN, YELLOW, RED: begin
        if (emergency && SAFE_CLEAR != 0 && (state_q == LEFT || state_q == GREEN)) begin
          state_d       = CLEAR;
          load          = 1'b1;
          saved_state_d = RED;
          saved_cnt_d   = '0;
        end else if (emergency) begin
          state_d       = ALLSTOP;
          load          = 1'b1;
          stop_d        = '0;
          saved_state_d = nxt_state;
          saved_cnt_d   = nxt_cnt;
        end else begin
          state_d = nxt_state;
          load    = term;
          inc     = 1'b1;
        end
      end
      CLEAR: begin
        state_d = term ? ALLSTOP : CLEAR;
        load    = term;
        inc     = 1'b1;
        stop_d  = '0;
      end
      ALLSTOP: begin
        stop_d = stop_q == STOP_LAST ? stop_q : stop_q + 1'b1;
        if (!emergency && stop_q == STOP_LAST) begin
          state_d  = saved_state_q;
          load     = 1'b1;
          load_val = saved_cnt_q;
        end
      end
      default: begin
        state_d = LEFT;
        load    = 1'b1;
      end
    endcase
  end
  always_comb begin
    out        = state_q == LEFT ? LIGHT_LEFT : state_q == GREEN ? LIGHT_GREEN :
                 (state_q == YELLOW || state_q == CLEAR) ? LIGHT_YELLOW : LIGHT_RED;
    preempted  = state_q == CLEAR || state_q == ALLSTOP;
    cnt_remain = (state_q == ALLSTOP || state_q > CLEAR) ? '0 : remain;
  end
  assign phase = state_q;
endmodule
